// File: rtl/piso_frame_tx_pkg.sv
// Shared types, widths and helpers for the piso_frame_tx serial frame transmitter.
package piso_frame_tx_pkg;

   localparam int LIDAR_FRAME_W = 184;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      GAP   = 2'd2
   } state_t;

   // Counter width for n distinct values, never narrower than one bit.
   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/piso_frame_tx_if.sv
// Parallel input handshake and serial output bundle of piso_frame_tx.
interface piso_frame_tx_if import piso_frame_tx_pkg::*; #(
   parameter int DATA_W = LIDAR_FRAME_W
);
   logic [DATA_W-1:0] in_data;
   logic              in_valid;
   logic              in_ready;
   logic              ser_data;
   logic              ser_valid;
   logic              ser_sof;
   logic              bit_tick;
   logic              busy;

   modport master (
      output in_data, in_valid,
      input  in_ready, ser_data, ser_valid, ser_sof, bit_tick, busy
   );

   modport slave (
      input  in_data, in_valid,
      output in_ready, ser_data, ser_valid, ser_sof, bit_tick, busy
   );
endinterface

// File: rtl/piso_frame_tx_bit_tick_gen.sv
// Bit-period divider: pulses bit_tick on the last clk of every CLK_DIV-cycle bit period.
module bit_tick_gen import piso_frame_tx_pkg::*; #(
   parameter int CLK_DIV = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic bit_tick
);
   localparam int               DIV_W    = clog2_min1(CLK_DIV);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   logic [DIV_W-1:0] div_cnt;

   assign bit_tick = enable && (div_cnt == DIV_LAST);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div_cnt <= '0;
      end else if (clear || !enable || bit_tick) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= div_cnt + 1'b1;
      end
   end
endmodule

// File: rtl/piso_frame_tx.sv
// Parallel-in/serial-out frame transmitter with one-word holding buffer, bit-rate divider,
// selectable bit order, inter-frame gap and synchronous abort.
module piso_frame_tx import piso_frame_tx_pkg::*; #(
   parameter int DATA_W    = LIDAR_FRAME_W,
   parameter int CLK_DIV   = 1,
   parameter int MSB_FIRST = 1,
   parameter int GAP_BITS  = 0
) (
   input logic            clk,
   input logic            reset,
   input logic            abort,
   piso_frame_tx_if.slave bus
);
   localparam int               CNT_W    = clog2_min1(DATA_W);
   localparam int               GAP_W    = clog2_min1(GAP_BITS + 1);
   localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(DATA_W - 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);

   if (DATA_W < 2 || CLK_DIV < 1) begin : g_bad_params
      $error("piso_frame_tx: DATA_W must be >= 2 and CLK_DIV >= 1");
   end

   state_t            state, nxt_state;
   logic [DATA_W-1:0] hold, nxt_hold;
   logic              hold_full, nxt_hold_full;
   logic [DATA_W-1:0] shreg, nxt_shreg;
   logic [CNT_W-1:0]  bit_cnt, nxt_bit_cnt;
   logic [GAP_W-1:0]  gap_cnt, nxt_gap_cnt;
   logic              ser_data, nxt_ser_data;
   logic              ser_valid, nxt_ser_valid;
   logic              ser_sof, nxt_ser_sof;
   logic              bit_tick;
   logic              accept, last_bit, gap_end, frame_done, load;

   function automatic logic out_bit(input logic [DATA_W-1:0] v);
      return (MSB_FIRST != 0) ? v[DATA_W-1] : v[0];
   endfunction

   function automatic logic [DATA_W-1:0] advance(input logic [DATA_W-1:0] v);
      return (MSB_FIRST != 0) ? {v[DATA_W-2:0], 1'b0} : {1'b0, v[DATA_W-1:1]};
   endfunction

   assign bus.in_ready  = !reset && !hold_full && !abort;
   assign bus.ser_data  = ser_data;
   assign bus.ser_valid = ser_valid;
   assign bus.ser_sof   = ser_sof;
   assign bus.bit_tick  = bit_tick;
   assign bus.busy      = (state != IDLE) || hold_full;

   assign accept     = bus.in_valid && bus.in_ready;
   assign last_bit   = (state == SHIFT) && bit_tick && (bit_cnt == BIT_LAST);
   assign gap_end    = (state == GAP) && bit_tick && (gap_cnt == GAP_LAST);
   assign frame_done = (last_bit && (GAP_BITS == 0)) || gap_end;
   // A queued word follows the previous frame (or gap) with no idle cycle in between.
   assign load       = !abort && hold_full && ((state == IDLE) || frame_done);

   bit_tick_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_bit_tick_gen (
      .clk      (clk),
      .reset    (reset),
      .clear    (load || abort),
      .enable   (state != IDLE),
      .bit_tick (bit_tick)
   );

   always_comb begin
      // NOTE: every next-state value gets a default first, so no path can infer a latch.
      nxt_state     = state;
      nxt_hold      = hold;
      nxt_hold_full = hold_full;
      nxt_shreg     = shreg;
      nxt_bit_cnt   = bit_cnt;
      nxt_gap_cnt   = gap_cnt;
      nxt_ser_sof   = ser_sof;

      if (accept) begin
         nxt_hold      = bus.in_data;
         nxt_hold_full = 1'b1;
      end

      unique case (state)
         SHIFT: begin
            if (bit_tick) begin
               nxt_shreg   = advance(shreg);
               nxt_bit_cnt = bit_cnt + 1'b1;
               nxt_ser_sof = 1'b0;
               if (last_bit) begin
                  nxt_bit_cnt = '0;
                  nxt_gap_cnt = '0;
                  nxt_state   = (GAP_BITS > 0) ? GAP : IDLE;
               end
            end
         end
         GAP: begin
            if (bit_tick) begin
               nxt_gap_cnt = gap_cnt + 1'b1;
               if (gap_end) begin
                  nxt_gap_cnt = '0;
                  nxt_state   = IDLE;
               end
            end
         end
         default: ;
      endcase

      if (load) begin
         nxt_shreg     = hold;
         nxt_hold_full = 1'b0;
         nxt_bit_cnt   = '0;
         nxt_gap_cnt   = '0;
         nxt_state     = SHIFT;
         nxt_ser_sof   = 1'b1;
      end

      if (abort) begin
         nxt_state     = IDLE;
         nxt_hold_full = 1'b0;
         nxt_shreg     = '0;
         nxt_bit_cnt   = '0;
         nxt_gap_cnt   = '0;
         nxt_ser_sof   = 1'b0;
      end

      nxt_ser_valid = (nxt_state == SHIFT);
      nxt_ser_data  = nxt_ser_valid && out_bit(nxt_shreg);
   end

   // NOTE: the holding buffer is reset along with the control state, so no X can ever reach ser_data.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         hold      <= '0;
         hold_full <= 1'b0;
         shreg     <= '0;
         bit_cnt   <= '0;
         gap_cnt   <= '0;
         ser_data  <= 1'b0;
         ser_valid <= 1'b0;
         ser_sof   <= 1'b0;
      end else begin
         state     <= nxt_state;
         hold      <= nxt_hold;
         hold_full <= nxt_hold_full;
         shreg     <= nxt_shreg;
         bit_cnt   <= nxt_bit_cnt;
         gap_cnt   <= nxt_gap_cnt;
         ser_data  <= nxt_ser_data;
         ser_valid <= nxt_ser_valid;
         ser_sof   <= nxt_ser_sof;
      end
   end
endmodule

// File: tb/tb_piso_frame_tx.sv
// Scoreboard bench for piso_frame_tx across four parameter sets sharing one clock and reset.
module tb_piso_frame_tx;
   import piso_frame_tx_pkg::*;

   logic clk = 1'b0;
   logic reset;
   logic abort_a, abort_b, abort_c, abort_d;

   always #5 clk = ~clk;

   piso_frame_tx_if #(.DATA_W(8))             bus_a ();
   piso_frame_tx_if #(.DATA_W(8))             bus_b ();
   piso_frame_tx_if #(.DATA_W(8))             bus_c ();
   piso_frame_tx_if #(.DATA_W(LIDAR_FRAME_W)) bus_d ();

   piso_frame_tx #(.DATA_W(8), .CLK_DIV(1), .MSB_FIRST(1), .GAP_BITS(0))
      dut_a (.clk(clk), .reset(reset), .abort(abort_a), .bus(bus_a));
   piso_frame_tx #(.DATA_W(8), .CLK_DIV(3), .MSB_FIRST(0), .GAP_BITS(0))
      dut_b (.clk(clk), .reset(reset), .abort(abort_b), .bus(bus_b));
   piso_frame_tx #(.DATA_W(8), .CLK_DIV(2), .MSB_FIRST(1), .GAP_BITS(2))
      dut_c (.clk(clk), .reset(reset), .abort(abort_c), .bus(bus_c));
   piso_frame_tx #(.DATA_W(LIDAR_FRAME_W), .CLK_DIV(1), .MSB_FIRST(1), .GAP_BITS(0))
      dut_d (.clk(clk), .reset(reset), .abort(abort_d), .bus(bus_d));

   int   checks   = 0;
   int   failures = 0;
   logic exp_q[$];
   logic obs_bits[$];
   logic val_tr[$];
   logic sof_tr[$];
   logic rdy_tr[$];
   int   n_tick;

   // Records one DUT's serial outputs on falling edges for a fixed window.
   task automatic capture(input int sel, input int cycles);
      logic v, d, s, t, r;
      obs_bits.delete(); val_tr.delete(); sof_tr.delete(); rdy_tr.delete();
      n_tick = 0;
      repeat (cycles) begin
         @(negedge clk);
         case (sel)
            0: begin v = bus_a.ser_valid; d = bus_a.ser_data; s = bus_a.ser_sof; t = bus_a.bit_tick; r = bus_a.in_ready; end
            1: begin v = bus_b.ser_valid; d = bus_b.ser_data; s = bus_b.ser_sof; t = bus_b.bit_tick; r = bus_b.in_ready; end
            2: begin v = bus_c.ser_valid; d = bus_c.ser_data; s = bus_c.ser_sof; t = bus_c.bit_tick; r = bus_c.in_ready; end
            default: begin v = bus_d.ser_valid; d = bus_d.ser_data; s = bus_d.ser_sof; t = bus_d.bit_tick; r = bus_d.in_ready; end
         endcase
         val_tr.push_back(v);
         sof_tr.push_back(s);
         rdy_tr.push_back(r);
         if (v) obs_bits.push_back(d);
         if (t) n_tick++;
      end
   endtask

   // Pushes the expected serial bits for a word, then offers it until accepted.
   task automatic send(input int sel, input logic [LIDAR_FRAME_W-1:0] w);
      int width, div;
      bit msb;
      bit acc;
      case (sel)
         0:       begin width = 8;             div = 1; msb = 1'b1; end
         1:       begin width = 8;             div = 3; msb = 1'b0; end
         2:       begin width = 8;             div = 2; msb = 1'b1; end
         default: begin width = LIDAR_FRAME_W; div = 1; msb = 1'b1; end
      endcase
      for (int i = 0; i < width; i++) begin
         int idx;
         idx = msb ? (width - 1 - i) : i;
         repeat (div) exp_q.push_back(w[idx]);
      end
      case (sel)
         0:       begin bus_a.in_data = w[7:0]; bus_a.in_valid = 1'b1; end
         1:       begin bus_b.in_data = w[7:0]; bus_b.in_valid = 1'b1; end
         2:       begin bus_c.in_data = w[7:0]; bus_c.in_valid = 1'b1; end
         default: begin bus_d.in_data = w;      bus_d.in_valid = 1'b1; end
      endcase
      acc = 1'b0;
      for (int k = 0; k < 200 && !acc; k++) begin
         case (sel)
            0:       acc = bus_a.in_ready;
            1:       acc = bus_b.in_ready;
            2:       acc = bus_c.in_ready;
            default: acc = bus_d.in_ready;
         endcase
         @(negedge clk);
      end
      bus_a.in_valid = 1'b0; bus_b.in_valid = 1'b0; bus_c.in_valid = 1'b0; bus_d.in_valid = 1'b0;
      checks++;
      if (!acc) begin
         failures++;
         $display("FAIL send_accept dut%0d: in_ready stayed 0 for 200 cycles, required acceptance", sel);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      abort_a = 1'b0; abort_b = 1'b0; abort_c = 1'b0; abort_d = 1'b0;
      bus_a.in_valid = 1'b0; bus_b.in_valid = 1'b0; bus_c.in_valid = 1'b0; bus_d.in_valid = 1'b0;
      bus_a.in_data = '0; bus_b.in_data = '0; bus_c.in_data = '0; bus_d.in_data = '0;
      repeat (3) @(negedge clk);
      checks++;
      if ({bus_a.in_ready, bus_b.in_ready, bus_c.in_ready, bus_d.in_ready} !== 4'b0000) begin
         failures++;
         $display("FAIL reset_in_ready: got %b%b%b%b, required 0000", bus_a.in_ready, bus_b.in_ready, bus_c.in_ready, bus_d.in_ready);
      end
      checks++;
      if ({bus_a.ser_valid, bus_a.ser_data, bus_a.ser_sof, bus_a.bit_tick, bus_a.busy} !== 5'b00000) begin
         failures++;
         $display("FAIL reset_outputs_a: got v/d/sof/tick/busy=%b%b%b%b%b, required 00000",
                  bus_a.ser_valid, bus_a.ser_data, bus_a.ser_sof, bus_a.bit_tick, bus_a.busy);
      end
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if ({bus_a.in_ready, bus_b.in_ready, bus_c.in_ready, bus_d.in_ready} !== 4'b1111) begin
         failures++;
         $display("FAIL post_reset_in_ready: got %b%b%b%b, required 1111", bus_a.in_ready, bus_b.in_ready, bus_c.in_ready, bus_d.in_ready);
      end
      checks++;
      if ({bus_d.ser_valid, bus_d.bit_tick, bus_d.busy} !== 3'b000) begin
         failures++;
         $display("FAIL post_reset_idle_d: got v/tick/busy=%b%b%b, required 000", bus_d.ser_valid, bus_d.bit_tick, bus_d.busy);
      end
   endtask

   task automatic test_msb_first();
      int nv = 0, ns = 0, first_v = -1, last_v = -1, n = 0;
      exp_q.delete();
      send(0, 8'hA5);
      checks++;
      if (bus_a.ser_valid !== 1'b0) begin
         failures++;
         $display("FAIL msb_latency: ser_valid=%b right after accept, required 0", bus_a.ser_valid);
      end
      capture(0, 12);
      foreach (val_tr[k]) begin
         if (val_tr[k]) begin nv++; if (first_v < 0) first_v = k; last_v = k; end
         if (sof_tr[k]) ns++;
      end
      checks++;
      if (nv != 8 || first_v != 0 || last_v != 7) begin
         failures++;
         $display("FAIL msb_valid_window: got %0d cycles at %0d..%0d, required 8 at 0..7", nv, first_v, last_v);
      end
      checks++;
      if (ns != 1 || sof_tr[0] !== 1'b1) begin
         failures++;
         $display("FAIL msb_sof: got %0d sof cycles (first=%b), required 1 on first bit", ns, sof_tr[0]);
      end
      checks++;
      if (n_tick != 8) begin
         failures++;
         $display("FAIL msb_ticks: got %0d, required 8", n_tick);
      end
      checks++;
      if (obs_bits.size() != exp_q.size()) begin
         failures++;
         $display("FAIL msb_bit_count: got %0d, required %0d", obs_bits.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_bits.size() > 0) begin
         logic e, o;
         e = exp_q.pop_front(); o = obs_bits.pop_front();
         checks++;
         if (o !== e) begin failures++; $display("FAIL msb_bit[%0d]: got %b, required %b", n, o, e); end
         n++;
      end
      exp_q.delete();
      checks++;
      if (bus_a.busy !== 1'b0) begin
         failures++;
         $display("FAIL msb_busy_after: got %b, required 0", bus_a.busy);
      end
   endtask

   task automatic test_lsb_div();
      int nv = 0, ns = 0, first_v = -1, n = 0;
      exp_q.delete();
      send(1, 8'h01);
      capture(1, 30);
      foreach (val_tr[k]) begin
         if (val_tr[k]) begin nv++; if (first_v < 0) first_v = k; end
         if (sof_tr[k]) ns++;
      end
      checks++;
      if (nv != 24 || first_v != 0) begin
         failures++;
         $display("FAIL lsb_valid_window: got %0d cycles from %0d, required 24 from 0", nv, first_v);
      end
      checks++;
      if (ns != 3) begin
         failures++;
         $display("FAIL lsb_sof_len: got %0d, required 3", ns);
      end
      checks++;
      if (n_tick != 8) begin
         failures++;
         $display("FAIL lsb_ticks: got %0d, required 8", n_tick);
      end
      checks++;
      if (obs_bits.size() != exp_q.size()) begin
         failures++;
         $display("FAIL lsb_bit_count: got %0d, required %0d", obs_bits.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_bits.size() > 0) begin
         logic e, o;
         e = exp_q.pop_front(); o = obs_bits.pop_front();
         checks++;
         if (o !== e) begin failures++; $display("FAIL lsb_bit[%0d]: got %b, required %b", n, o, e); end
         n++;
      end
      exp_q.delete();
   endtask

   task automatic test_back_to_back();
      int nv = 0, ns = 0, first_v = -1, last_v = -1, n = 0;
      exp_q.delete();
      fork
         begin send(0, 8'hF0); send(0, 8'h0F); end
         capture(0, 24);
      join
      foreach (val_tr[k]) begin
         if (val_tr[k]) begin nv++; if (first_v < 0) first_v = k; last_v = k; end
         if (sof_tr[k]) ns++;
      end
      checks++;
      if (nv != 16 || (last_v - first_v) != 15 || first_v != 1) begin
         failures++;
         $display("FAIL b2b_contiguous: got %0d cycles at %0d..%0d, required 16 at 1..16", nv, first_v, last_v);
      end
      checks++;
      if (rdy_tr[4] !== 1'b0) begin
         failures++;
         $display("FAIL b2b_ready_hold_full: got %b, required 0", rdy_tr[4]);
      end
      checks++;
      if (ns != 2) begin
         failures++;
         $display("FAIL b2b_sof: got %0d, required 2", ns);
      end
      checks++;
      if (obs_bits.size() != exp_q.size()) begin
         failures++;
         $display("FAIL b2b_bit_count: got %0d, required %0d", obs_bits.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_bits.size() > 0) begin
         logic e, o;
         e = exp_q.pop_front(); o = obs_bits.pop_front();
         checks++;
         if (o !== e) begin failures++; $display("FAIL b2b_bit[%0d]: got %b, required %b", n, o, e); end
         n++;
      end
      exp_q.delete();
   endtask

   task automatic test_gap();
      int nv = 0, sof_rise = 0, first_v = -1, run_end = -1, gap_len = 0, n = 0;
      logic prev_sof = 1'b0;
      exp_q.delete();
      fork
         begin send(2, 8'hC3); send(2, 8'h5A); end
         capture(2, 60);
      join
      foreach (val_tr[k]) begin
         if (val_tr[k]) begin nv++; if (first_v < 0) first_v = k; end
         if (sof_tr[k] && !prev_sof) sof_rise++;
         prev_sof = sof_tr[k];
      end
      if (first_v >= 0) begin
         for (int k = first_v; k < val_tr.size(); k++) begin
            if (!val_tr[k]) break;
            run_end = k;
         end
         for (int k = run_end + 1; k < val_tr.size(); k++) begin
            if (val_tr[k]) break;
            gap_len++;
         end
      end
      checks++;
      if (nv != 32) begin
         failures++;
         $display("FAIL gap_valid_count: got %0d, required 32", nv);
      end
      checks++;
      if (gap_len != 4) begin
         failures++;
         $display("FAIL gap_length: got %0d idle cycles, required 4", gap_len);
      end
      checks++;
      if (sof_rise != 2) begin
         failures++;
         $display("FAIL gap_sof_pulses: got %0d, required 2", sof_rise);
      end
      checks++;
      if (n_tick != 20) begin
         failures++;
         $display("FAIL gap_ticks: got %0d, required 20", n_tick);
      end
      while (exp_q.size() > 0 && obs_bits.size() > 0) begin
         logic e, o;
         e = exp_q.pop_front(); o = obs_bits.pop_front();
         checks++;
         if (o !== e) begin failures++; $display("FAIL gap_bit[%0d]: got %b, required %b", n, o, e); end
         n++;
      end
      exp_q.delete();
   endtask

   task automatic test_abort();
      int nv = 0, n = 0;
      exp_q.delete();
      send(0, 8'hFF);
      send(0, 8'h3C);
      repeat (2) @(negedge clk);
      checks++;
      if ({bus_a.ser_valid, bus_a.ser_data, bus_a.busy} !== 3'b111) begin
         failures++;
         $display("FAIL abort_pre: got v/d/busy=%b%b%b at bit 3, required 111", bus_a.ser_valid, bus_a.ser_data, bus_a.busy);
      end
      abort_a = 1'b1;
      #1;
      checks++;
      if (bus_a.in_ready !== 1'b0) begin
         failures++;
         $display("FAIL abort_in_ready: got %b during abort, required 0", bus_a.in_ready);
      end
      @(negedge clk);
      abort_a = 1'b0;
      exp_q.delete();
      #1;
      checks++;
      if ({bus_a.ser_valid, bus_a.ser_data, bus_a.ser_sof, bus_a.bit_tick, bus_a.busy, bus_a.in_ready} !== 6'b000001) begin
         failures++;
         $display("FAIL abort_flush: got v/d/sof/tick/busy/rdy=%b%b%b%b%b%b, required 000001",
                  bus_a.ser_valid, bus_a.ser_data, bus_a.ser_sof, bus_a.bit_tick, bus_a.busy, bus_a.in_ready);
      end
      @(negedge clk);
      send(0, 8'h81);
      capture(0, 20);
      foreach (val_tr[k]) if (val_tr[k]) nv++;
      checks++;
      if (nv != 8) begin
         failures++;
         $display("FAIL abort_after_count: got %0d valid cycles, required 8", nv);
      end
      while (exp_q.size() > 0 && obs_bits.size() > 0) begin
         logic e, o;
         e = exp_q.pop_front(); o = obs_bits.pop_front();
         checks++;
         if (o !== e) begin failures++; $display("FAIL abort_after_bit[%0d]: got %b, required %b", n, o, e); end
         n++;
      end
      exp_q.delete();
   endtask

   task automatic test_async_reset();
      logic [LIDAR_FRAME_W-1:0] p2;
      int nv, n;
      exp_q.delete();
      send(3, {46{4'hB}});
      repeat (20) @(negedge clk);
      checks++;
      if (bus_d.ser_valid !== 1'b1) begin
         failures++;
         $display("FAIL areset_midframe: ser_valid=%b, required 1", bus_d.ser_valid);
      end
      #2 reset = 1'b1;
      #1;
      checks++;
      if ({bus_d.ser_valid, bus_d.ser_data, bus_d.ser_sof, bus_d.bit_tick, bus_d.busy, bus_d.in_ready} !== 6'b000000) begin
         failures++;
         $display("FAIL areset_immediate: got v/d/sof/tick/busy/rdy=%b%b%b%b%b%b, required 000000",
                  bus_d.ser_valid, bus_d.ser_data, bus_d.ser_sof, bus_d.bit_tick, bus_d.busy, bus_d.in_ready);
      end
      exp_q.delete();
      @(negedge clk);
      reset = 1'b0;
      #1;
      checks++;
      if (bus_d.in_ready !== 1'b1) begin
         failures++;
         $display("FAIL areset_release_ready: got %b, required 1", bus_d.in_ready);
      end
      @(negedge clk);
      p2 = LIDAR_FRAME_W'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
      p2[LIDAR_FRAME_W-1] = 1'b1;
      for (int f = 0; f < 2; f++) begin
         nv = 0;
         n  = 0;
         send(3, (f == 0) ? LIDAR_FRAME_W'(1) : p2);
         capture(3, 200);
         foreach (val_tr[k]) if (val_tr[k]) nv++;
         checks++;
         if (nv != LIDAR_FRAME_W) begin
            failures++;
            $display("FAIL wide_frame%0d_len: got %0d, required %0d", f, nv, LIDAR_FRAME_W);
         end
         while (exp_q.size() > 0 && obs_bits.size() > 0) begin
            logic e, o;
            e = exp_q.pop_front(); o = obs_bits.pop_front();
            checks++;
            if (o !== e) begin failures++; $display("FAIL wide_frame%0d_bit[%0d]: got %b, required %b", f, n, o, e); end
            n++;
         end
         exp_q.delete();
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_msb_first();
      test_lsb_div();
      test_back_to_back();
      test_gap();
      test_abort();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
